seg_scan_driver: RTL
====================

// Module: seg_scan_driver
// PURPOSE
//  Display-side end of the 32-bit BCD data / 8-bit valid interface driven by the clock/timer blocks.
//  - Double-buffers one display frame.
//  - Time-multiplexes the 8 nibbles onto a 4-bit digit bus plus a 3-bit digit index.
//  - Skips digits whose valid bit is clear.
//  - Applies new data only at frame boundaries, so a digit never tears mid-scan.
// PARAMETERS
//  SCAN_DIV   100000  clk cycles each digit is shown (1 kHz digit rate at 100 MHz); must be >= 2
//  BLINK_DIV  250     frames per blink half-period (used only with SEG_BLINK_EN)
// PORTS
//  clk           in   1   single system clock, rising edge
//  rst_n         in   1   reset; one clock; reset is asynchronous and active-low
//  output_data   in   32  8 BCD nibbles; nibble k = bits [4k+3:4k], digit 0 = rightmost
//  output_valid  in   8   per-digit enable; bit k gates nibble k
//  load          in   1   request to capture output_data/output_valid
//  load_ready    out  1   1 = pending buffer empty; a load is accepted this cycle
//  seg_data      out  4   nibble of the digit currently shown; 4'h0 when blank
//  seg_an        out  3   index of the digit currently shown
//  blank         out  1   1 = no digit lit this slot
//  blink_mask    in   8   (SEG_BLINK_EN only) per-digit blink enable
// BEHAVIOUR
//  - Reset (async assert, sync release):
//    - Outputs: seg_data=0, seg_an=0, blank=1, load_ready=1.
//    - Internal: shadow data=0, shadow valid=0, pending empty, div_cnt=0, blink phase=0.
//  - Handshake:
//    - A transfer occurs when load & load_ready at a posedge.
//    - Data and valid are copied into the pending buffer; pending becomes full.
//    - load_ready = !pending_full (registered).
//    - A load while load_ready=0 is ignored, with no side effects.
//  - Scan:
//    - div_cnt counts 0..SCAN_DIV-1. The cycle with div_cnt==SCAN_DIV-1 is a tick.
//    - On a tick, the next index is the first index cyclically after seg_an whose shadow valid bit is 1.
//    - If seg_an itself is the only valid digit, the index stays and the step counts as a wrap.
//  - Frame boundary: a tick where the next index <= current index (wrap), or shadow valid==0.
//  - Frame-boundary update:
//    - If pending is full, pending is copied to shadow, pending empties, and load_ready=1 on the next cycle.
//    - The next index is then computed from the NEW valid mask, starting from index 0 inclusive.
//  - Simultaneous load and frame boundary with pending empty: load lands in pending; it is applied at the following boundary.
//  - Output timing:
//    - Outputs are registered and update the cycle after a tick (or after reset). They hold constant between ticks.
//    - seg_data = shadow nibble[seg_an]; blank = !shadow_valid[seg_an].
//  - Shadow valid==0: seg_an held 0, blank=1, seg_data=0; boundaries still fire every tick, so a pending load is applied.
//  - Reset mid-frame: the scan restarts at index 0 with a blank shadow, and any pending load is discarded.
// CONFIGURATION
//  - SEG_BLINK_EN defined:
//    - blink_mask port exists.
//    - Phase toggles every BLINK_DIV frame boundaries.
//    - While phase=1, digits with blink_mask[k]=1 show blank=1, seg_data=0. seg_an still steps over them.
//    - blink_mask is sampled live, not buffered.
//  - SEG_BLINK_EN undefined: no blink_mask port, no phase counter; blank depends only on valid.
// TESTING  (SCAN_DIV=4, BLINK_DIV=2 in sim)
//  1. Drop rst_n mid-scan -> same edge seg_an=0, seg_data=0, blank=1, load_ready=1; no ticks while low.
//  2. Load 32'h00095830 / 8'hFF -> after first boundary, seg_an steps 0..7 every 4 clk;
//     seg_data 0,3,8,5,9,0,0,0; blank=0.
//  3. Load valid 8'h3F -> seg_an cycles 0..5 only; indices 6,7 never appear.
//  4. Load A, then B while load_ready=0 -> B ignored; A applied at next wrap; load_ready=1 one cycle later.
//  5. Load valid 8'h00 -> blank=1, seg_an=0 persistently; a later load of 8'h01 shows digit 0 after the next tick.
//  6. SEG_BLINK_EN, blink_mask=8'h01 -> digit 0 blanked on alternate 2-frame periods, other digits steady.

Source files
------------

// File: rtl/seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seg_scan_driver
//   Display-side end of the 32-bit BCD / 8-bit valid interface. One frame is
//   double-buffered (pending -> shadow), and the shadow frame is time-
//   multiplexed one digit at a time onto a 4-bit digit bus plus a 3-bit index.
//   Digits whose valid bit is clear are skipped. New frames are only promoted
//   to the shadow at a frame boundary, so a digit never changes mid-scan.
//
// Optional feature macro: SEG_BLINK_EN (adds blink_mask port and blink phase).
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   output_data  in   8 BCD nibbles, nibble k = bits [4k+3:4k]
//   output_valid in   per-digit enable, bit k gates nibble k
//   load         in   capture request for output_data/output_valid
//   load_ready   out  1 = pending buffer empty, a load is accepted
//   blink_mask   in   (SEG_BLINK_EN) per-digit blink enable, sampled live
//   seg_data     out  nibble of the digit shown, 0 when blank
//   seg_an       out  index of the digit shown
//   blank        out  1 = no digit lit this slot
// ---------------------------------------------------------------------------
module seg_scan_driver #(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned BLINK_DIV = 250
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] output_data,
    input  logic [7:0]  output_valid,
    input  logic        load,
    output logic        load_ready,
`ifdef SEG_BLINK_EN
    input  logic [7:0]  blink_mask,
`endif
    output logic [3:0]  seg_data,
    output logic [2:0]  seg_an,
    output logic        blank
);

    localparam int unsigned  DW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(SCAN_DIV - 1);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [31:0]   shd_data_q, shd_data_d;
    logic [7:0]    shd_valid_q, shd_valid_d;
    logic [31:0]   pnd_data_q, pnd_data_d;
    logic [7:0]    pnd_valid_q, pnd_valid_d;
    logic          pnd_full_q, pnd_full_d;
    logic [2:0]    an_q, an_d;
    logic [3:0]    data_q, data_d;
    logic          blank_q, blank_d;

    logic          tick, boundary, apply, accept, wrap;
    logic          step_found;
    logic [2:0]    cand, step_idx, first_idx;
    logic          hide;
    logic          visible;

    // Scan timing, next-index search and double-buffer control.
    always_comb begin
        tick       = (div_cnt_q == LAST);
        div_cnt_d  = tick ? '0 : div_cnt_q + 1'b1;

        // First valid index cyclically after the current one; when the
        // current digit is the only valid one the search lands back on it.
        step_idx   = an_q;
        step_found = 1'b0;
        cand       = '0;
        for (int unsigned k = 1; k <= 8; k++) begin
            cand = an_q + 3'(k);
            if (!step_found && shd_valid_q[cand]) begin
                step_idx   = cand;
                step_found = 1'b1;
            end
        end
        wrap = (step_idx <= an_q);

        // Lowest set bit of the incoming mask (index 0 inclusive).
        first_idx = '0;
        for (int unsigned k = 8; k > 0; k--) begin
            if (pnd_valid_q[k-1]) first_idx = 3'(k - 1);
        end

        boundary = tick && (wrap || (shd_valid_q == '0));
        apply    = boundary && pnd_full_q;
        accept   = load && !pnd_full_q;

        pnd_data_d  = pnd_data_q;
        pnd_valid_d = pnd_valid_q;
        pnd_full_d  = pnd_full_q;
        if (accept) begin
            pnd_data_d  = output_data;
            pnd_valid_d = output_valid;
            pnd_full_d  = 1'b1;
        end else if (apply) begin
            pnd_full_d  = 1'b0;
        end

        shd_data_d  = apply ? pnd_data_q  : shd_data_q;
        shd_valid_d = apply ? pnd_valid_q : shd_valid_q;

        an_d = an_q;
        if (tick) begin
            if (apply)                    an_d = first_idx;
            else if (shd_valid_q == '0)   an_d = '0;
            else                          an_d = step_idx;
        end
    end

`ifdef SEG_BLINK_EN
    localparam int unsigned BW = $clog2(BLINK_DIV + 1);
    logic [BW-1:0] frm_cnt_q, frm_cnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        frm_cnt_d = frm_cnt_q;
        phase_d   = phase_q;
        if (boundary) begin
            if (frm_cnt_q == BW'(BLINK_DIV - 1)) begin
                frm_cnt_d = '0;
                phase_d   = ~phase_q;
            end else begin
                frm_cnt_d = frm_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_cnt_q <= '0;
            phase_q   <= 1'b0;
        end else begin
            frm_cnt_q <= frm_cnt_d;
            phase_q   <= phase_d;
        end
    end

    assign hide = phase_d & blink_mask[an_d];
`else
    assign hide = 1'b0;
`endif

    // Registered digit outputs, refreshed only on a tick and computed from
    // the frame that will be in the shadow after this edge.
    always_comb begin
        visible = shd_valid_d[an_d] & ~hide;
        data_d  = data_q;
        blank_d = blank_q;
        if (tick) begin
            data_d  = visible ? shd_data_d[{an_d, 2'b00} +: 4] : 4'h0;
            blank_d = ~visible;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q   <= '0;
            shd_data_q  <= '0;
            shd_valid_q <= '0;
            pnd_data_q  <= '0;
            pnd_valid_q <= '0;
            pnd_full_q  <= 1'b0;
            an_q        <= '0;
            data_q      <= '0;
            blank_q     <= 1'b1;
        end else begin
            div_cnt_q   <= div_cnt_d;
            shd_data_q  <= shd_data_d;
            shd_valid_q <= shd_valid_d;
            pnd_data_q  <= pnd_data_d;
            pnd_valid_q <= pnd_valid_d;
            pnd_full_q  <= pnd_full_d;
            an_q        <= an_d;
            data_q      <= data_d;
            blank_q     <= blank_d;
        end
    end

    assign load_ready = ~pnd_full_q;
    assign seg_data   = data_q;
    assign seg_an     = an_q;
    assign blank      = blank_q;

endmodule
